// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_BURST
    } arb_state_e;

    localparam int BEAT_W = 5;

    // Fixed burst length in beats; 0 for SINGLE and undefined-length INCR.
    function automatic logic [BEAT_W-1:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return BEAT_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  return BEAT_W'(8);
            HBURST_WRAP16, HBURST_INCR16: return BEAT_W'(16);
            default:                      return '0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    output logic          found,
    output logic [MW-1:0] idx
);

    logic [N-1:0] rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [MW-1:0] pos;
            assign pos     = MW'((int'(start) + gi) % N);
            assign rot[gi] = req[pos];
        end
    endgenerate

    // Walk downwards so the smallest offset from start is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = MW'((int'(start) + i) % N);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst hold; locked transfers need AHB_ARB_LOCK_EN.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic                   hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    arb_state_e             state_reg, state_next;
    logic [MW-1:0]          master_reg, master_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [BEAT_W-1:0]      beat_reg, beat_next;
    logic                   lock_reg, lock_next;
    logic [BEAT_W-1:0]      blen;
    logic [MW-1:0]          start_idx, pick_idx;
    logic                   pick_found, owner_req, lock_hold, rearb;

    assign owner_req = hbusreq[master_reg];
    assign blen      = burst_len(hburst);
    assign start_idx = (master_reg == MW'(NUM_MASTERS - 1)) ? '0 : master_reg + 1'b1;

    ahb_rr_picker #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_picker (
        .req   (hbusreq),
        .start (start_idx),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef AHB_ARB_LOCK_EN
    assign lock_hold = hlock[master_reg] & owner_req;
    assign lock_next = hready ? hlock[master_reg] : lock_reg;
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign lock_hold    = 1'b0;
    assign lock_next    = 1'b0;
`endif

    always_comb begin
        rearb       = 1'b0;
        state_next  = state_reg;
        master_next = master_reg;
        beat_next   = beat_reg;
        if (hready) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (|hbusreq) rearb = 1'b1;
                end
                ARB_OWN: begin
                    if (htrans == HTRANS_NONSEQ) begin
                        if (hburst == HBURST_SINGLE) begin
                            rearb = 1'b1;
                        end else if (blen != '0) begin
                            state_next = ARB_BURST;
                            beat_next  = BEAT_W'(1);
                        end
                    end else if (!owner_req && htrans == HTRANS_IDLE) begin
                        rearb = 1'b1;
                    end
                end
                ARB_BURST: begin
                    // ERROR is checked first so it beats a coincident last beat.
                    if (hresp == HRESP_ERROR) begin
                        state_next = ARB_OWN;
                        beat_next  = '0;
                    end else if (htrans == HTRANS_SEQ) begin
                        if (beat_reg == blen - 1'b1) rearb = 1'b1;
                        else beat_next = beat_reg + 1'b1;
                    end
                end
                default: state_next = ARB_IDLE;
            endcase

            if (rearb) begin
                beat_next = '0;
                if (lock_hold) begin
                    state_next = ARB_OWN;
                end else if (pick_found) begin
                    master_next = pick_idx;
                    state_next  = ARB_OWN;
                end else begin
                    master_next = '0;
                    state_next  = ARB_IDLE;
                end
            end
        end
        grant_next              = '0;
        grant_next[master_next] = 1'b1;
    end

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            state_reg  <= ARB_IDLE;
            master_reg <= '0;
            grant_reg  <= NUM_MASTERS'(1);
            beat_reg   <= '0;
            lock_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            master_reg <= master_next;
            grant_reg  <= grant_next;
            beat_reg   <= beat_next;
            lock_reg   <= lock_next;
        end
    end

    assign hgrant    = grant_reg;
    assign hmaster   = master_reg;
    assign hmastlock = lock_reg;

endmodule
